// File: rtl/conv_20_acc_sat.sv
// Accumulate-and-requantize stage behind the conv_20 multiplier: sums KERNEL_SIZE
// products onto a per-window bias, then rounds, shifts and saturates to OUT_WIDTH.
module conv_20_acc_sat #(
    parameter int PROD_WIDTH  = 24,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int KERNEL_SIZE = 9,
    parameter int SHIFT       = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic signed [PROD_WIDTH-1:0] prod_data,
    input  logic                        prod_valid,
    output logic                        prod_ready,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sat_flag
);
    localparam int CNT_W = $clog2(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_SIZE - 1);
    localparam logic signed [ACC_WIDTH:0] ROUND = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] MAX_V =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_V =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic        [CNT_W-1:0]     cnt;

    logic                        last;
    logic                        accept;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   r;
    logic signed [OUT_WIDTH-1:0] res;
    logic                        sat;

    assign last       = (cnt == LAST_CNT);
    // Only the closing product stalls on a pending result; earlier terms keep flowing.
    assign prod_ready = !(last && out_valid && !out_ready);
    assign accept     = prod_valid && prod_ready;

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign base     = (cnt == '0) ? bias : acc;
    assign sum      = base + prod_ext;

    // One extra bit keeps the rounding add from wrapping before the arithmetic shift.
    assign rnd = {sum[ACC_WIDTH-1], sum} + ROUND;
    assign r   = rnd >>> SHIFT;

    always_comb begin
        res = r[OUT_WIDTH-1:0];
        sat = 1'b0;
        if (r > MAX_V) begin
            res = MAX_V[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (r < MIN_V) begin
            res = MIN_V[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                acc <= sum;
                if (last) begin
                    cnt       <= '0;
                    out_data  <= res;
                    out_valid <= 1'b1;
                    if (sat)
                        sat_flag <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
